traffic_monitor: RTL and testbench

Passive checker on the far end of the traffic-controller output interface. It samples the two light buses and the countdown value every clock and flags encoding, conflict, sequence, countdown and stall violations. Sticky error flags and a one-cycle error pulse are reported. It sits beside the controller at the top level and in benches, and drives nothing back into the controller.

---
 rtl/traffic_monitor.sv | 135 +++++++++++++
 tb/tb_traffic_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_monitor.sv
// Passive checker for the traffic-controller output interface: flags light
// encoding, conflict, sequence, countdown and stall violations.
module traffic_monitor #(
    parameter int unsigned MAX_COUNT = 60,
    parameter int unsigned MAX_PHASE = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light1,
    input  logic [2:0] light2,
    input  logic [5:0] count,
    input  logic       clr,
    output logic [4:0] err,
    output logic       err_pulse,
    output logic [7:0] cycles,
    output logic       synced
);
    localparam int unsigned     HW        = $clog2(MAX_PHASE + 1);
    localparam logic [2:0]      RED       = 3'b100;
    localparam logic [2:0]      YEL       = 3'b010;
    localparam logic [2:0]      GRN       = 3'b001;
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(MAX_PHASE);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_PHASE - 1);
    localparam logic [5:0]      CNT_MAX   = 6'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_SYNC = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t        state_r, state_s;
    logic [2:0]    prev1_r, prev2_r;
    logic [5:0]    prev_cnt_r;
    logic [HW-1:0] hold_r, hold_s;
    logic [4:0]    err_r, det_s;
    logic          pulse_r;
    logic [7:0]    cycles_r;
    logic          synced_r;
    logic          chg_s, cur_ok_s, prv_ok_s, seq_bad_s, cnt_bad_s, cyc_inc_s;

    function automatic logic one_hot(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || ((p == GRN) && (c == YEL)) ||
               ((p == YEL) && (c == RED)) || ((p == RED) && (c == GRN));
    endfunction

    // Violation detection, hold counter and state sequencing.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        det_s     = 5'b00000;
        cyc_inc_s = 1'b0;
        chg_s     = (light1 != prev1_r) || (light2 != prev2_r);
        cur_ok_s  = one_hot(light1) && one_hot(light2);
        prv_ok_s  = one_hot(prev1_r) && one_hot(prev2_r);
        seq_bad_s = !step_ok(prev1_r, light1) || !step_ok(prev2_r, light2);
        // A phase change must follow a zero count and load a legal value.
        if (chg_s) begin
            cnt_bad_s = (prev_cnt_r != 6'd0) || (count == 6'd0) || (count > CNT_MAX);
        end else begin
            cnt_bad_s = (prev_cnt_r == 6'd0) || (count != (prev_cnt_r - 6'd1));
        end
        case (state_r)
            ST_INIT: begin
                state_s = ST_SYNC;
                hold_s  = '0;
            end
            ST_SYNC, ST_RUN: begin
                det_s[0] = !cur_ok_s;
                det_s[1] = !light1[2] && !light2[2];
                if (chg_s) begin
                    hold_s = '0;
                end else if (hold_r != HOLD_MAX) begin
                    hold_s   = hold_r + 1'b1;
                    det_s[4] = (hold_r == HOLD_LAST);
                end else begin
                    hold_s = hold_r;
                end
                if (state_r == ST_RUN) begin
                    if (cur_ok_s && prv_ok_s) begin
                        det_s[2] = seq_bad_s;
                        det_s[3] = cnt_bad_s;
                    end else begin
                        det_s[2] = 1'b0;
                        det_s[3] = 1'b0;
                    end
                    cyc_inc_s = (prev1_r == RED) && (light1 == GRN) && (cycles_r != 8'd255);
                end else if (chg_s && cur_ok_s && prv_ok_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            default: begin
                state_s = ST_INIT;
                hold_s  = '0;
            end
        endcase
    end

    // Sample history, sticky flags and reported status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            prev1_r    <= 3'b000;
            prev2_r    <= 3'b000;
            prev_cnt_r <= 6'd0;
            hold_r     <= '0;
            err_r      <= 5'b00000;
            pulse_r    <= 1'b0;
            cycles_r   <= 8'd0;
            synced_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            prev1_r    <= light1;
            prev2_r    <= light2;
            prev_cnt_r <= count;
            hold_r     <= hold_s;
            // New detections override a coincident clear.
            err_r      <= (clr ? 5'b00000 : err_r) | det_s;
            pulse_r    <= |det_s;
            cycles_r   <= cyc_inc_s ? (cycles_r + 8'd1) : cycles_r;
            synced_r   <= (state_s == ST_RUN);
        end
    end

    assign err       = err_r;
    assign err_pulse = pulse_r;
    assign cycles    = cycles_r;
    assign synced    = synced_r;
endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor: rule-level reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_traffic_monitor;
    localparam int MAXC = 60;
    localparam int MAXP = 100;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] light1 = 3'b000;
    logic [2:0] light2 = 3'b000;
    logic [5:0] count = 6'd0;
    logic       clr = 1'b0;
    logic [4:0] err;
    logic       err_pulse;
    logic [7:0] cycles;
    logic       synced;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int         m_phase = 0;     // 0 first sample, 1 searching, 2 locked
    int         m_edge  = 0;
    int         m_ref   = 0;     // edge index of the last light change
    logic [2:0] p1, p2;
    int         pc;
    logic [4:0] m_err = 5'b00000;
    logic       m_pulse = 1'b0;
    int         m_cycles = 0;
    logic       m_synced = 1'b0;
    bit         m_valid = 1'b0;

    traffic_monitor #(.MAX_COUNT(MAXC), .MAX_PHASE(MAXP)) dut (
        .clk(clk), .rst(rst), .light1(light1), .light2(light2), .count(count),
        .clr(clr), .err(err), .err_pulse(err_pulse), .cycles(cycles), .synced(synced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit onehot(input logic [2:0] l);
        return $countones(l) == 1;
    endfunction

    // position in the ring green -> yellow -> red -> green
    function automatic int ring(input logic [2:0] l);
        return (l == G) ? 0 : (l == Y) ? 1 : 2;
    endfunction

    function automatic bit legal_move(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (ring(c) == (ring(p) + 1) % 3);
    endfunction

    task automatic model_step();
        logic [4:0] det;
        bit chg, cok, pok;
        m_edge++;
        if (rst) begin
            m_phase = 0; p1 = 3'b000; p2 = 3'b000; pc = 0;
            m_err = 5'b00000; m_pulse = 1'b0; m_cycles = 0; m_synced = 1'b0;
            m_ref = m_edge; m_valid = 1'b1;
        end else begin
            det = 5'b00000;
            chg = (light1 != p1) || (light2 != p2);
            cok = onehot(light1) && onehot(light2);
            pok = onehot(p1) && onehot(p2);
            if (m_phase == 0) begin
                m_ref = m_edge;
            end else begin
                if (!cok) det[0] = 1'b1;
                if (light1 != R && light2 != R) det[1] = 1'b1;
                if (chg) m_ref = m_edge;
                else if (m_edge - m_ref == MAXP) det[4] = 1'b1;
                if (m_phase == 2 && cok && pok) begin
                    if (!legal_move(p1, light1) || !legal_move(p2, light2)) det[2] = 1'b1;
                    if (chg) begin
                        if (pc != 0 || count == 0 || int'(count) > MAXC) det[3] = 1'b1;
                    end else begin
                        if (pc == 0 || int'(count) != pc - 1) det[3] = 1'b1;
                    end
                end
            end
            if (m_phase == 2 && p1 == R && light1 == G && m_cycles < 255) m_cycles++;
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1 && chg && cok && pok) m_phase = 2;
            m_err    = clr ? det : (m_err | det);
            m_pulse  = |det;
            m_synced = (m_phase == 2);
            p1 = light1; p2 = light2; pc = int'(count);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model_err", {27'd0, err}, {27'd0, m_err});
            chk("model_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
            chk("model_cycles", {24'd0, cycles}, m_cycles);
            chk("model_synced", {31'd0, synced}, {31'd0, m_synced});
        end
    end

    task automatic step(input logic [2:0] l1, input logic [2:0] l2, input int c);
        light1 = l1; light2 = l2; count = 6'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input logic [2:0] l1, input logic [2:0] l2, input int n);
        for (int k = n; k >= 0; k--) step(l1, l2, k);
    endtask

    task automatic legal_cycle();
        phase(G, R, 5); phase(Y, R, 3); phase(R, G, 5); phase(R, Y, 3);
    endtask

    initial begin
        int pulses, pulse_at;
        step(3'b000, 3'b000, 0);
        step(3'b000, 3'b000, 0);
        chk("rst_err", {27'd0, err}, 32'd0);
        chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_cycles", {24'd0, cycles}, 32'd0);
        chk("rst_synced", {31'd0, synced}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) legal_cycle();
        phase(G, R, 5);
        chk("legal_err", {27'd0, err}, 32'd0);
        chk("legal_cycles", {24'd0, cycles}, 32'd3);
        chk("legal_synced", {31'd0, synced}, 32'd1);

        phase(Y, R, 3); phase(R, G, 5); phase(R, Y, 3);
        step(G, R, 5); step(G, R, 4);
        step(3'b011, R, 3);
        chk("enc_err", {27'd0, err}, 32'h01);
        chk("enc_pulse_hi", {31'd0, err_pulse}, 32'd1);
        step(G, R, 2);
        chk("enc_pulse_lo", {31'd0, err_pulse}, 32'd0);
        step(G, R, 1); step(G, R, 0);
        chk("enc_sticky", {27'd0, err}, 32'h01);
        clr = 1'b1; step(Y, R, 3); clr = 1'b0;
        chk("clr_err", {27'd0, err}, 32'd0);
        phase(Y, R, 2); phase(R, G, 5);

        step(G, G, 5);
        chk("conflict_err", {27'd0, err}, 32'h02);
        clr = 1'b1; step(G, G, 4); clr = 1'b0;
        chk("clr_vs_conflict", {27'd0, err}, 32'h02);
        phase(G, G, 3); phase(G, Y, 3); phase(G, R, 5);
        clr = 1'b1; step(R, G, 5); clr = 1'b0;
        chk("seq_g_to_r", {27'd0, err}, 32'h04);

        step(R, G, 4); step(R, G, 2);
        chk("count_skip", {27'd0, err}, 32'h0C);
        step(R, G, 1); step(R, G, 0);
        clr = 1'b1; step(R, Y, 3); clr = 1'b0;
        chk("clr_again", {27'd0, err}, 32'd0);
        step(R, Y, 2); step(G, R, 5);
        chk("count_early_change", {27'd0, err}, 32'h08);
        phase(G, R, 4);
        step(Y, R, 61);
        chk("count_over_max", {31'd0, err_pulse}, 32'd1);
        clr = 1'b1; step(Y, R, 60); clr = 1'b0;
        chk("clr_third", {27'd0, err}, 32'd0);
        phase(Y, R, 59);
        step(G, G, 5);
        chk("pre_rst_err", {27'd0, err}, 32'h06);

        rst = 1'b1; step(G, G, 4); rst = 1'b0;
        chk("midrun_rst_err", {27'd0, err}, 32'd0);
        chk("midrun_rst_cycles", {24'd0, cycles}, 32'd0);
        chk("midrun_rst_synced", {31'd0, synced}, 32'd0);
        step(G, R, 0);
        chk("init_synced", {31'd0, synced}, 32'd0);

        pulses = 0; pulse_at = 0;
        for (int k = 1; k <= 105; k++) begin
            step(G, R, 0);
            if (err_pulse === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk("stuck_pulses", pulses, 32'd1);
        chk("stuck_at", pulse_at, 32'd100);
        chk("stuck_err", {27'd0, err}, 32'h10);
        step(Y, R, 3);
        chk("run_synced", {31'd0, synced}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(Y, R, 0);
            chk("count_zero_pulse", {31'd0, err_pulse}, 32'd1);
        end
        chk("final_err", {27'd0, err}, 32'h18);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
